// File: rtl/ws2812b_pkg.sv
// Shared WS2812B timing defaults and receiver state encoding, used by both the
// transmitter and the receiver so that both sides agree on the bit timing.
package ws2812b_pkg;

  localparam int unsigned DEF_STRIP_LEN  = 120;
  localparam int unsigned DEF_COLOR_BITS = 24;
  localparam int unsigned DEF_T_MIN_HI   = 10;
  localparam int unsigned DEF_T_THRESH   = 60;
  localparam int unsigned DEF_T_MAX_HI   = 150;
  localparam int unsigned DEF_T_RES      = 5000;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } rx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the serial line with registered rise/fall strobes
// aligned to the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      rise  <= meta & ~level;
      fall  <= ~meta & level;
    end
  end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B serial receiver: decodes pulse-width bits into LSB-first color words
// and writes them to sequential LED addresses, with framing/overflow checks.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int unsigned STRIP_LEN  = DEF_STRIP_LEN,
  parameter int unsigned COLOR_BITS = DEF_COLOR_BITS,
  parameter int unsigned T_MIN_HI   = DEF_T_MIN_HI,
  parameter int unsigned T_THRESH   = DEF_T_THRESH,
  parameter int unsigned T_MAX_HI   = DEF_T_MAX_HI,
  parameter int unsigned T_RES      = DEF_T_RES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           din,
  output logic                           write_en,
  output logic [$clog2(STRIP_LEN)-1:0]   write_addr,
  output logic [COLOR_BITS-1:0]          dout,
  output logic                           frame_done,
  output logic [$clog2(STRIP_LEN+1)-1:0] pixel_count,
  output logic                           err_frame,
  output logic                           err_ovf
);

  localparam int unsigned ADDR_W = $clog2(STRIP_LEN);
  localparam int unsigned PIX_W  = $clog2(STRIP_LEN + 1);
  localparam int unsigned BIT_W  = $clog2(COLOR_BITS);
  localparam int unsigned CNT_W  = $clog2(max_u(T_RES, T_MAX_HI) + 1);

  logic level, rise, fall;

  sync_edge u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e             state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d, cnt_inc;
  logic                  bit_valid, bit_val, pulse_err, frame_end;
  logic [BIT_W-1:0]      bit_cnt;
  logic [COLOR_BITS-2:0] shreg;

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Line timing FSM: qualifies pulses and emits bit / error / frame-end events.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    pulse_err = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_SYNC: begin
        if (level) begin
          cnt_d = '0;
        end else if (cnt >= CNT_W'(T_RES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end
      end
      ST_HI: begin
        if ((cnt >= CNT_W'(T_MAX_HI)) || (fall && (cnt < CNT_W'(T_MIN_HI - 1)))) begin
          pulse_err = 1'b1;
          state_d   = ST_SYNC;
          cnt_d     = '0;
        end else if (fall) begin
          bit_valid = 1'b1;
          bit_val   = (cnt >= CNT_W'(T_THRESH - 1));
          state_d   = ST_LO;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LO: begin
        if (rise) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt >= CNT_W'(T_RES - 1)) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Word assembly, pixel addressing and registered status strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      write_addr  <= '0;
      pixel_count <= '0;
      dout        <= '0;
      write_en    <= 1'b0;
      frame_done  <= 1'b0;
      err_frame   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      write_en   <= 1'b0;
      frame_done <= 1'b0;
      err_frame  <= 1'b0;
      err_ovf    <= 1'b0;

      if (write_en && (write_addr != ADDR_W'(STRIP_LEN - 1))) begin
        write_addr <= write_addr + ADDR_W'(1);
      end

      if (frame_done) begin
        write_addr  <= '0;
        bit_cnt     <= '0;
        pixel_count <= '0;
      end

      if (pulse_err) begin
        err_frame <= 1'b1;
        bit_cnt   <= '0;
        shreg     <= '0;
      end else if (bit_valid) begin
        if (bit_cnt == BIT_W'(COLOR_BITS - 1)) begin
          bit_cnt <= '0;
          shreg   <= '0;
          // Past the end of the strip the word is counted as overflow, never written.
          if (pixel_count < PIX_W'(STRIP_LEN)) begin
            write_en    <= 1'b1;
            dout        <= {bit_val, shreg};
            pixel_count <= pixel_count + PIX_W'(1);
          end else begin
            err_ovf <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          shreg   <= {bit_val, shreg[COLOR_BITS-2:1]};
        end
      end else if (frame_end) begin
        frame_done <= 1'b1;
        err_frame  <= (bit_cnt != '0);
        bit_cnt    <= '0;
        shreg      <= '0;
      end
    end
  end

endmodule

// File: doc/ws2812b_rx.md
WS2812B_RX -- requirements
Module: ws2812b_rx

Interface
REQ-001 SHALL expose parameters (name, default, meaning): STRIP_LEN, 120, LEDs per frame.
REQ-002 COLOR_BITS, 24, bits per LED word.
REQ-003 T_MIN_HI, 10, shortest legal high pulse in clk cycles; shorter is a glitch.
REQ-004 T_THRESH, 60, high-time threshold: high pulse ≥ T_THRESH decodes as 1, otherwise 0.
REQ-005 T_MAX_HI, 150, longest legal high pulse.
REQ-006 T_RES, 5000, low time that marks frame end / reset.
REQ-007 Ports (name, direction, width, meaning): clk, in, 1, single clock (100 MHz nominal).
REQ-008 reset, in, 1, asynchronous, active-low.
REQ-009 din, in, 1, asynchronous serial line.
REQ-010 write_en, out, 1, one-cycle pixel-valid strobe; no backpressure.
REQ-011 write_addr, out, $clog2(STRIP_LEN), LED index of the current pixel.
REQ-012 dout, out, COLOR_BITS, decoded color word.
REQ-013 frame_done, out, 1, one-cycle strobe at frame end.
REQ-014 pixel_count, out, $clog2(STRIP_LEN+1), pixels accepted in the frame; valid while frame_done=1.
REQ-015 err_frame, out, 1, one-cycle strobe on a framing error.
REQ-016 err_ovf, out, 1, one-cycle strobe on strip overflow.

Function
REQ-017 din SHALL pass through a 2-FF synchronizer; all edge and timing logic SHALL use the synchronized signal.
REQ-018 FSM states: SYNC, IDLE, HI, LO.
REQ-019 SYNC: count consecutive low cycles; a high input clears the count; count reaching T_RES-1 goes to IDLE.
REQ-020 IDLE: rising edge goes to HI and clears the counter.
REQ-021 HI: count cycles. On a falling edge, bit = (count+1 ≥ T_THRESH), then go to LO.
REQ-022 HI: a falling edge with count+1 < T_MIN_HI, or the count reaching T_MAX_HI, SHALL pulse err_frame, discard the partial word and go to SYNC.
REQ-023 Bits SHALL be assembled LSB first: the first bit received is dout[0], matching the frame-buffer serializer.
REQ-024 LO: rising edge goes to HI. Low count reaching T_RES-1 is frame end; go to IDLE.
REQ-025 When the COLOR_BITS-th bit is decoded, write_en SHALL assert the next cycle with dout and write_addr stable for that cycle; then write_addr increments and the bit counter clears.
REQ-026 Pixels arriving after STRIP_LEN pixels SHALL NOT assert write_en; each one SHALL pulse err_ovf once; write_addr holds at STRIP_LEN-1.
REQ-027 At frame end: frame_done pulses for one cycle with pixel_count; write_addr, the bit counter and the pixel count return to 0 in the following cycle.
REQ-028 Frame end with a nonzero bit counter: the partial word is discarded, and err_frame and frame_done pulse in the same cycle.
REQ-029 Counters SHALL saturate and never wrap. The timing counter width is $clog2(max(T_RES, T_MAX_HI)+1).
REQ-030 Pulse outputs SHALL be registered and never high for two consecutive cycles.

Reset
REQ-031 On reset=0 (asynchronous): state=SYNC; all counters, shift register and synchronizer = 0; write_en, frame_done, err_frame and err_ovf = 0; write_addr=0; dout=0; pixel_count=0.
REQ-032 Reset asserted mid-frame SHALL drop all partial data; after release, no pixel SHALL be accepted until a full T_RES low period is seen.

Structure
REQ-033 A shared package ws2812b_pkg SHALL hold the state enum and default timing constants, so the transmitter and receiver use identical values.
REQ-034 The synchronizer plus edge detector SHALL be one sub-module, sync_edge (outputs: level, rise, fall).

Verification
REQ-035 Reset release, din low for 5000 cycles, then 24 bits of 0x00A5F0 (high 80 for 1 / 40 for 0, period 125) -> one write_en with addr 0, dout 0x00A5F0, at the 2nd clk after the last synced falling edge.
REQ-036 Full 120-pixel frame from the ws2812b transmitter, loop-backed -> 120 write_en strobes at addrs 0..119 with matching data; frame_done with pixel_count=120 after 5000 low cycles.
REQ-037 121 pixels, then T_RES low -> 120 writes, one err_ovf, frame_done with pixel_count=120.
REQ-038 12 bits, then T_RES low -> no write_en; err_frame and frame_done in the same cycle with pixel_count=0.
REQ-039 High pulse of 5 cycles, and separately a high held for 200 cycles -> err_frame each time; state returns to SYNC; the next pixel is ignored until 5000 low cycles.
REQ-040 Boundary bits: high of 59 cycles decodes as 0 and high of 60 decodes as 1. Reset asserted at bit 10 of a pixel -> all outputs 0 immediately, and no spurious write after release.
